bsr_chain: RTL and testbench

Parametrised boundary-scan register: WIDTH scan cells in one chain, with a shared capture/shift/update sequence and a normal/test output mux. It sits between the device pins and core logic, downstream of the TAP controller, and is selected as the data register for EXTEST and SAMPLE/PRELOAD. Compared with the single-cell form, it adds a shift-position counter, a frame-complete pulse, a defined update reset value, and fixed priority rules for coincident controls.

---
 rtl/bsr_chain.sv | 72 +++++++
 tb/tb_bsr_chain.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bsr_chain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bsr_chain : WIDTH-cell boundary-scan register with shift counter and frame pulse
// Revision  : 1.0
// ---------------------------------------------------------------------------
module bsr_chain #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] UPD_RESET = {WIDTH{1'b0}}
) (
  input  logic                     tck,
  input  logic                     trst_n,
  input  logic [WIDTH-1:0]         pin,
  output logic [WIDTH-1:0]         pout,
  input  logic                     sin,
  output logic                     sout,
  input  logic                     capture_dr,
  input  logic                     shift_dr,
  input  logic                     update_dr,
  input  logic                     mode,
  output logic [$clog2(WIDTH)-1:0] shift_cnt,
  output logic                     frame_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] ur_q, ur_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fd_q, fd_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    fd_d  = 1'b0;
    // Update always sees the pre-edge shift stage, whatever the shift stage does.
    ur_d  = update_dr ? sr_q : ur_q;
    if (capture_dr) begin
      sr_d  = pin;
      cnt_d = '0;
    end else if (shift_dr) begin
      sr_d = {sin, sr_q[WIDTH-1:1]};
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        fd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      sr_q  <= '0;
      ur_q  <= UPD_RESET;
      cnt_q <= '0;
      fd_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      ur_q  <= ur_d;
      cnt_q <= cnt_d;
      fd_q  <= fd_d;
    end
  end

  assign sout       = sr_q[0];
  assign pout       = mode ? ur_q : pin;
  assign shift_cnt  = cnt_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_bsr_chain.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bsr_chain : directed self-checking bench for bsr_chain (WIDTH=8)
// Revision     : 1.0
// ---------------------------------------------------------------------------
module tb_bsr_chain;

  localparam int WIDTH = 8;
  localparam logic [WIDTH-1:0] UPD_RESET = 8'hA5;

  logic             tck = 1'b0;
  logic             trst_n;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             sin;
  logic             sout;
  logic             capture_dr;
  logic             shift_dr;
  logic             update_dr;
  logic             mode;
  logic [2:0]       shift_cnt;
  logic             frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  bsr_chain #(.WIDTH(WIDTH), .UPD_RESET(UPD_RESET)) dut (
    .tck        (tck),
    .trst_n     (trst_n),
    .pin        (pin),
    .pout       (pout),
    .sin        (sin),
    .sout       (sout),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr),
    .mode       (mode),
    .shift_cnt  (shift_cnt),
    .frame_done (frame_done)
  );

  always #5 tck = ~tck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge tck);
    #2 trst_n = 1'b0;
    #1;
  endtask

  logic [WIDTH-1:0] v;

  initial begin
    trst_n = 1'b0; pin = '0; sin = 1'b0; capture_dr = 1'b0; shift_dr = 1'b0;
    update_dr = 1'b0; mode = 1'b1;
    #12 trst_n = 1'b1;
    tick();

    // Reset asserted between edges takes effect immediately
    pulse_reset();
    check("rst_pout", pout, UPD_RESET);
    check("rst_sout", sout, 0);
    check("rst_cnt", shift_cnt, 0);
    check("rst_fd", frame_done, 0);
    #1 trst_n = 1'b1;
    tick();

    // Capture 0x3C then shift out LSB first
    v = 8'h3C;
    pin = v; capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    check("cap_sout", sout, v[0]);
    check("cap_cnt", shift_cnt, 0);
    shift_dr = 1'b1; sin = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("sh%0d_sout", k), sout, (k < 8) ? 32'(v[k]) : 32'd0);
      check($sformatf("sh%0d_cnt", k), shift_cnt, k % 8);
      check($sformatf("sh%0d_fd", k), frame_done, (k == 8) ? 1 : 0);
    end

    // Shift in 0x96, then update and view through the mode mux
    v = 8'h96;
    for (int k = 0; k < 8; k++) begin
      sin = v[k];
      tick();
    end
    shift_dr = 1'b0; update_dr = 1'b1;
    tick();
    update_dr = 1'b0;
    check("upd_pout", pout, 8'h96);
    check("upd_sout", sout, 0);
    tick();
    check("hold_pout", pout, 8'h96);
    check("hold_cnt", shift_cnt, 0);
    mode = 1'b0; pin = 8'h11;
    #1 check("mode0_pout", pout, 8'h11);
    mode = 1'b1;
    #1 check("mode1_pout", pout, 8'h96);

    // Capture beats shift and clears the counter; update takes pre-shift sr
    shift_dr = 1'b1; sin = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    check("pre_cap_cnt", shift_cnt, 3);
    pin = 8'hF0; capture_dr = 1'b1;
    tick();
    capture_dr = 1'b0;
    check("capsh_cnt", shift_cnt, 0);
    check("capsh_sout", sout, 0);
    sin = 1'b1; update_dr = 1'b1;
    tick();
    check("updsh_pout", pout, 8'hF0);
    check("updsh_cnt", shift_cnt, 1);
    shift_dr = 1'b0;
    tick();
    update_dr = 1'b0;
    check("upd2_pout", pout, 8'hF8);

    // Reset mid-frame discards the partial frame
    shift_dr = 1'b1; sin = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    check("mid_cnt", shift_cnt, 4);
    pulse_reset();
    check("mid_rst_cnt", shift_cnt, 0);
    check("mid_rst_sout", sout, 0);
    check("mid_rst_pout", pout, UPD_RESET);
    #1 trst_n = 1'b1;
    sin = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("post%0d_fd", k), frame_done, (k == 8) ? 1 : 0);
    end

    // 20 continuous shifts: pulses after edges 8 and 16 only
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("run%0d_fd", k), frame_done, (k == 8 || k == 16) ? 1 : 0);
    end
    check("run_cnt", shift_cnt, 4);

    // Pause freezes the counter
    shift_dr = 1'b0;
    tick();
    tick();
    check("pause_cnt", shift_cnt, 4);
    check("pause_fd", frame_done, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
